// File: rtl/ext_ram_pkg.sv
// Shared types and RAM geometry for the external LLR RAM stream controller.
package ext_ram_pkg;

    localparam int unsigned RAM_DATA_WIDTH = 5;
    localparam int unsigned RAM_ADDR_WIDTH = 8;
    localparam int unsigned RAM_DEPTH      = 256;

    // Read credits: reads in flight plus words parked in the return buffer.
    localparam int unsigned RD_CREDITS     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        READ = 2'd2
    } state_e;

endpackage

// File: rtl/rd_out_fifo.sv
// Three-entry read-return buffer between the RAM read port and the output stream.
module rd_out_fifo
    import ext_ram_pkg::*;
#(
    parameter int unsigned WIDTH = RAM_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    localparam int unsigned DEPTH = RD_CREDITS;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]       wr_ptr_q;
    logic [1:0]       rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == 2'(DEPTH));
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot for a push into a full buffer.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, wrap-around pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= (wr_ptr_q == 2'(DEPTH - 1)) ? 2'd0 : wr_ptr_q + 2'd1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == 2'(DEPTH - 1)) ? 2'd0 : rd_ptr_q + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ext_ram_stream_ctrl.sv
// Loads one LLR frame from a stream into the external RAM and streams it back in address order.
module ext_ram_stream_ctrl
    import ext_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int unsigned FRAME_LEN  = RAM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_ld,
    input  logic                  start_rd,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  frame_loaded,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_we,
    output logic                  ram_cs,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    // One extra bit so a full 2^ADDR_WIDTH frame never wraps before the compare.
    localparam int unsigned     CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    state_e                  state_q;
    logic                    start_ld_q;
    logic                    start_rd_q;
    logic                    frame_loaded_q;
    logic [CNT_W-1:0]        wr_cnt_q;
    logic [CNT_W-1:0]        rd_cnt_q;
    logic [CNT_W-1:0]        pop_cnt_q;
    logic                    inflight_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    load_fire;
    logic                    rd_issue;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [1:0]              fifo_count;
    logic [2:0]              outstanding;

    assign load_fire   = (state_q == LOAD) && s_valid;
    assign outstanding = 3'(fifo_count) + 3'(inflight_q);
    assign rd_issue    = (state_q == READ) && (rd_cnt_q < LEN)
                         && (outstanding < 3'(RD_CREDITS)) && !fifo_full;
    assign pop         = m_valid && m_ready;

    assign s_ready      = (state_q == LOAD);
    assign busy         = (state_q != IDLE);
    assign frame_loaded = frame_loaded_q;
    assign m_valid      = !fifo_empty;

    // RAM port: driven in the cycle of a write beat or read issue, otherwise parked.
    assign ram_cs      = load_fire || rd_issue;
    assign ram_we      = load_fire;
    assign ram_address = load_fire ? wr_cnt_q[ADDR_WIDTH-1:0]
                       : rd_issue  ? rd_cnt_q[ADDR_WIDTH-1:0]
                       : addr_q;
    assign ram_data_in = load_fire ? s_data : wdata_q;

    rd_out_fifo #(
        .WIDTH (DATA_WIDTH)
    ) u_rd_out_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .data_i  (ram_data_out),
        .pop_i   (pop),
        .data_o  (m_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Control FSM, frame counters, start capture and parked RAM port values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            start_ld_q     <= 1'b0;
            start_rd_q     <= 1'b0;
            frame_loaded_q <= 1'b0;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            pop_cnt_q      <= '0;
            inflight_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
        end else begin
            addr_q     <= ram_address;
            wdata_q    <= ram_data_in;
            inflight_q <= rd_issue;
            // Starts are only heard in IDLE and act one edge after they are sampled.
            start_ld_q <= start_ld && (state_q == IDLE);
            start_rd_q <= start_rd && (state_q == IDLE);
            case (state_q)
                IDLE: begin
                    if (start_ld_q) begin
                        state_q        <= LOAD;
                        frame_loaded_q <= 1'b0;
                        wr_cnt_q       <= '0;
                    end else if (start_rd_q && frame_loaded_q) begin
                        state_q   <= READ;
                        rd_cnt_q  <= '0;
                        pop_cnt_q <= '0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        wr_cnt_q <= wr_cnt_q + CNT_W'(1);
                        if (wr_cnt_q == LAST) begin
                            state_q        <= IDLE;
                            frame_loaded_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                    if (pop) begin
                        pop_cnt_q <= pop_cnt_q + CNT_W'(1);
                        if (pop_cnt_q == LAST) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_ram_stream_ctrl.sv
// Scoreboard bench for ext_ram_stream_ctrl: a 256-word instance and a 5-word instance.
module tb_ext_ram_stream_ctrl;

    logic       clk;
    logic       rst;
    logic       start_ld     [2];
    logic       start_rd     [2];
    logic [4:0] s_data       [2];
    logic       s_valid      [2];
    logic       s_ready      [2];
    logic [4:0] m_data       [2];
    logic       m_valid      [2];
    logic       m_ready      [2];
    logic       busy         [2];
    logic       frame_loaded [2];
    logic [7:0] ram_address  [2];
    logic [4:0] ram_data_in  [2];
    logic       ram_we       [2];
    logic       ram_cs       [2];
    logic [4:0] ram_dout     [2];

    logic [4:0] mem   [2][256];
    logic [4:0] model [2][256];

    int         total_checks = 0;
    int         bad_checks   = 0;
    int         cyc          = 0;

    int         exp_wr [$];
    logic [4:0] exp_rd [$];

    int         ram_act [2];
    int         wr_seen, first_wr, last_wr;
    int         exp_rd_addr, issued, popped;
    int         first_valid_cyc, last_pop_cyc;
    bit         stall_prev [2];
    logic [4:0] held [2];

    ext_ram_stream_ctrl #(.DATA_WIDTH(5), .ADDR_WIDTH(8), .FRAME_LEN(256)) u_dut (
        .clk(clk), .rst(rst), .start_ld(start_ld[0]), .start_rd(start_rd[0]),
        .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]),
        .busy(busy[0]), .frame_loaded(frame_loaded[0]),
        .ram_address(ram_address[0]), .ram_data_in(ram_data_in[0]),
        .ram_we(ram_we[0]), .ram_cs(ram_cs[0]), .ram_data_out(ram_dout[0])
    );

    ext_ram_stream_ctrl #(.DATA_WIDTH(5), .ADDR_WIDTH(8), .FRAME_LEN(5)) u_dut_small (
        .clk(clk), .rst(rst), .start_ld(start_ld[1]), .start_rd(start_rd[1]),
        .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]),
        .busy(busy[1]), .frame_loaded(frame_loaded[1]),
        .ram_address(ram_address[1]), .ram_data_in(ram_data_in[1]),
        .ram_we(ram_we[1]), .ram_cs(ram_cs[1]), .ram_data_out(ram_dout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous single-port RAM models, one per instance.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_cs[d]) begin
                if (ram_we[d]) mem[d][ram_address[d]] <= ram_data_in[d];
                else           ram_dout[d] <= mem[d][ram_address[d]];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            bad_checks++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    // Monitor: RAM writes, read issue order, credit bound, output stream against the scoreboard.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_cs[d]) ram_act[d]++;
            if (ram_cs[d] && ram_we[d]) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", 32'(ram_address[d]), 32'hFFFF);
                end else begin
                    int e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(ram_address[d]), 32'(e >> 5));
                    check("wr_data", 32'(ram_data_in[d]), 32'(e & 31));
                end
                wr_seen++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (ram_cs[d] && !ram_we[d]) begin
                issued++;
                check("rd_addr", 32'(ram_address[d]), 32'(exp_rd_addr));
                exp_rd_addr++;
                check("outstanding_le3", 32'((issued - popped) <= 3), 1);
            end
            if (stall_prev[d] && !rst) begin
                check("stall_valid", 32'(m_valid[d]), 1);
                check("stall_data", 32'(m_data[d]), 32'(held[d]));
            end
            if (m_valid[d] && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid[d] && m_ready[d]) begin
                popped++;
                last_pop_cyc = cyc;
                if (exp_rd.size() == 0) check("rd_extra_word", 32'(m_data[d]), 32'hFFFF);
                else                    check("rd_data", 32'(m_data[d]), 32'(exp_rd.pop_front()));
            end
            stall_prev[d] = m_valid[d] && !m_ready[d] && !rst;
            held[d]       = m_data[d];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input int d);
        check("rst_s_ready", 32'(s_ready[d]), 0);
        check("rst_m_valid", 32'(m_valid[d]), 0);
        check("rst_m_data", 32'(m_data[d]), 0);
        check("rst_busy", 32'(busy[d]), 0);
        check("rst_frame_loaded", 32'(frame_loaded[d]), 0);
        check("rst_ram_cs", 32'(ram_cs[d]), 0);
        check("rst_ram_we", 32'(ram_we[d]), 0);
        check("rst_ram_address", 32'(ram_address[d]), 0);
        check("rst_ram_data_in", 32'(ram_data_in[d]), 0);
    endtask

    task automatic load_frame(input int d, input int n, input int off, input bit both);
        int guard;
        wr_seen  = 0;
        first_wr = -1;
        last_wr  = -1;
        start_ld[d] = 1'b1;
        start_rd[d] = both;
        step();
        start_ld[d] = 1'b0;
        start_rd[d] = 1'b0;
        step();
        check("ld_entered_ready", 32'(s_ready[d]), 1);
        check("ld_entered_busy", 32'(busy[d]), 1);
        check("ld_loaded_cleared", 32'(frame_loaded[d]), 0);
        for (int i = 0; i < n; i++) begin
            model[d][i] = 5'((i + off) % 32);
            s_data[d]   = model[d][i];
            s_valid[d]  = 1'b1;
            exp_wr.push_back(i * 32 + ((i + off) % 32));
            guard = 0;
            @(negedge clk);
            while (!s_ready[d] && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 50) check("ld_ready_timeout", 0, 1);
            step();
        end
        s_valid[d] = 1'b0;
        check("ld_writes", 32'(wr_seen), 32'(n));
        check("ld_span", 32'(last_wr - first_wr + 1), 32'(n));
        check("ld_pending", 32'(exp_wr.size()), 0);
        check("ld_frame_loaded", 32'(frame_loaded[d]), 1);
        check("ld_busy_end", 32'(busy[d]), 0);
    endtask

    task automatic read_frame(input int d, input int n, input int mode, input int abort_at);
        int lat;
        int guard;
        exp_rd_addr     = 0;
        issued          = 0;
        popped          = 0;
        first_valid_cyc = -1;
        last_pop_cyc    = -1;
        for (int i = 0; i < n; i++) exp_rd.push_back(model[d][i]);
        m_ready[d]  = (mode == 0);
        start_rd[d] = 1'b1;
        step();
        start_rd[d] = 1'b0;
        if (mode == 0) begin
            lat = 0;
            @(negedge clk);
            while (!m_valid[d] && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            check("rd_latency", 32'(lat), 3);
        end
        guard = 0;
        do begin
            step();
            guard++;
            if (mode == 1) m_ready[d] = 1'($urandom_range(0, 1));
            if (abort_at > 0 && popped >= abort_at) begin
                rst = 1'b1;
                #1;
                check("abort_m_valid", 32'(m_valid[d]), 0);
                check("abort_frame_loaded", 32'(frame_loaded[d]), 0);
                check("abort_busy", 32'(busy[d]), 0);
                check("abort_ram_cs", 32'(ram_cs[d]), 0);
                check("abort_words_before", 32'(popped), 32'(abort_at));
                exp_rd.delete();
                m_ready[d] = 1'b0;
                step();
                rst = 1'b0;
                return;
            end
        end while (busy[d] && guard < 5000);
        m_ready[d] = 1'b0;
        check("rd_no_timeout", 32'(guard < 5000), 1);
        check("rd_all_delivered", 32'(exp_rd.size()), 0);
        check("rd_word_count", 32'(popped), 32'(n));
        check("rd_frame_kept", 32'(frame_loaded[d]), 1);
        if (mode == 0) check("rd_no_gaps", 32'(last_pop_cyc - first_valid_cyc + 1), 32'(n));
        exp_rd.delete();
    endtask

    task automatic start_rd_ignored(input int d);
        int act0;
        act0        = ram_act[d];
        start_rd[d] = 1'b1;
        step();
        start_rd[d] = 1'b0;
        repeat (6) step();
        check("rd_ignored_busy", 32'(busy[d]), 0);
        check("rd_ignored_ram", 32'(ram_act[d] - act0), 0);
        check("rd_ignored_m_valid", 32'(m_valid[d]), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_ld[d]   = 1'b0;
            start_rd[d]   = 1'b0;
            s_data[d]     = 5'd0;
            s_valid[d]    = 1'b0;
            m_ready[d]    = 1'b0;
            ram_act[d]    = 0;
            stall_prev[d] = 1'b0;
        end
        repeat (3) step();
        check_reset_state(0);
        check_reset_state(1);
        rst = 1'b0;
        step();

        start_rd_ignored(1);

        load_frame(0, 256, 0, 1'b0);
        read_frame(0, 256, 0, 0);
        read_frame(0, 256, 1, 0);
        read_frame(0, 256, 0, 100);
        step();
        start_rd_ignored(0);

        load_frame(1, 5, 7, 1'b0);
        read_frame(1, 5, 0, 0);
        load_frame(1, 5, 19, 1'b1);
        read_frame(1, 5, 1, 0);
        read_frame(1, 5, 0, 0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
